// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder slice.
//   - dmem_state_e : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   - MEM_OP_*     : MEM-stage opcodes that reach this responder (lw / sw)
//   - WORD_BYTES   : bytes per RAM word
//   - access_err() : misaligned / out-of-range test on a captured request
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_e;

   localparam logic [4:0] MEM_OP_LW  = 5'b10100;
   localparam logic [4:0] MEM_OP_SW  = 5'b10101;
   localparam int         WORD_BYTES = 4;

   // byte_sel is addr[1:0]; word_off is (addr - base) in words, 32-bit wrap.
   function automatic logic access_err(input logic [1:0]  byte_sel,
                                       input logic [29:0] word_off,
                                       input logic [31:0] depth_words);
      return (byte_sel != 2'b00) || ({2'b00, word_off} >= depth_words);
   endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request/response bundle between the MEM stage and the
// data-memory responder.
//   master (MEM stage): drives ce_i, we_i, addr_i, wdata_i
//   slave  (responder): drives busy_o, ready_o, err_o, rdata_o
// The _i/_o suffixes are from the responder's point of view.
interface dmem_if;
   import dmem_pkg::*;

   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        ready_o;
   logic        err_o;
   logic [31:0] rdata_o;

   modport master (
      output ce_i, we_i, addr_i, wdata_i,
      input  busy_o, ready_o, err_o, rdata_o
   );

   modport slave (
      input  ce_i, we_i, addr_i, wdata_i,
      output busy_o, ready_o, err_o, rdata_o
   );

endinterface

// File: rtl/dmem_ram_array.sv
// dmem_ram_array: single-port synchronous RAM, DEPTH_WORDS x 32.
//   clk   : rising-edge clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata to idx, 0 = read idx into rdata
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read, held otherwise
module dmem_ram_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // NOTE: the array and its read register have no reset; contents persist
   // across rst and only control state in the responder is cleared.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory side of the MEM-stage load/store port.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any request in flight)
//   bus : dmem_if.slave - request in (ce/we/addr/wdata), response out
//         (busy/ready/err/rdata)
// A request is captured in IDLE, waits WAIT_STATES cycles, then completes
// with a one-cycle ready_o in RESP. Misaligned or out-of-range requests
// complete with err_o; their store is dropped and their load returns 0.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          ADDR_W      = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
);

   localparam logic [3:0]  LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [31:0] DEPTH_W  = 32'(DEPTH_WORDS);

   dmem_state_e state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        capture;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [29:0] cur_off;
   logic        acc_err;
   logic        ram_en, ram_we;
   logic [31:0] ram_rdata;
   logic        resp_load;
   logic [31:0] rdata_q, rdata_mux;

   // Word offset from BASE_ADDR. In IDLE it follows the live address so a
   // zero-wait load can issue its RAM read on the accept edge; afterwards it
   // follows the captured address. BASE_ADDR is the byte address of word 0
   // and therefore word aligned, so only its word bits take part.
   assign cur_off = ((state == IDLE) ? bus.addr_i[31:2] : addr_q[31:2]) - BASE_ADDR[31:2];
   assign acc_err = access_err(addr_q[1:0], cur_off, DEPTH_W);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_q <= 32'h0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rdata_q <= rdata_mux;
      end
   end

   // Captured request; later changes on the bus are ignored.
   always_ff @(posedge clk) begin
      if (capture) begin
         we_q    <= bus.we_i;
         addr_q  <= bus.addr_i;
         wdata_q <= bus.wdata_i;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves a latch behind.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ce_i) begin
               capture = 1'b1;
               cnt_nxt = 4'd0;
               if (WAIT_STATES == 0) begin
                  state_nxt = RESP;
                  ram_en    = !bus.we_i;   // read lands in RESP
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == LAST_CNT) begin
               state_nxt = RESP;
               ram_en    = !we_q;          // read lands in RESP
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            if (we_q && !acc_err) begin
               ram_en = 1'b1;
               ram_we = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   dmem_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en && !rst),         // reset in RESP must not commit a store
      .we    (ram_we),
      .idx   (cur_off[ADDR_W-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // rdata_o shows fresh load data during RESP and otherwise holds the last
   // completed load, so stores never disturb it.
   assign resp_load = (state == RESP) && !we_q;
   assign rdata_mux = resp_load ? (acc_err ? 32'h0 : ram_rdata) : rdata_q;

   assign bus.busy_o  = (state != IDLE);
   assign bus.ready_o = (state == RESP);
   assign bus.err_o   = (state == RESP) && acc_err;
   assign bus.rdata_o = rdata_mux;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Four instances share
// clk/rst: 0 = WAIT_STATES 1 (main), 1 = WAIT_STATES 0, 2 = WAIT_STATES 3,
// 3 = WAIT_STATES 1 with BASE_ADDR 0x1000. Expected responses are pushed to a
// scoreboard queue when a request is driven and popped on ready_o.
module tb_dmem_responder;

   typedef struct {
      string       tag;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce    [4];
   logic        we    [4];
   logic [31:0] addr  [4];
   logic [31:0] wdata [4];
   logic        busy  [4];
   logic        ready [4];
   logic        err   [4];
   logic [31:0] rdata [4];
   logic [31:0] last_rd [4];   // model of the held rdata_o per instance

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic int ws_of(input int s);
      return (s == 1) ? 0 : ((s == 2) ? 3 : 1);
   endfunction

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dmem_if bus ();
      dmem_responder #(
         .DEPTH_WORDS (1024),
         .ADDR_W      (10),
         .WAIT_STATES (ws_of(g)),
         .BASE_ADDR   ((g == 3) ? 32'h0000_1000 : 32'h0)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign bus.ce_i    = ce[g];
      assign bus.we_i    = we[g];
      assign bus.addr_i  = addr[g];
      assign bus.wdata_i = wdata[g];
      assign busy[g]     = bus.busy_o;
      assign ready[g]    = bus.ready_o;
      assign err[g]      = bus.err_o;
      assign rdata[g]    = bus.rdata_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input int s, input string tag);
      check({tag, ":busy"},  32'(busy[s]),  32'h0);
      check({tag, ":ready"}, 32'(ready[s]), 32'h0);
      check({tag, ":err"},   32'(err[s]),   32'h0);
      check({tag, ":rdata"}, rdata[s],      32'h0);
   endtask

   // One complete request on instance s, entered and left #1 after an edge
   // with the instance in IDLE. e_load is the stored word a good load returns.
   task automatic xact(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err,
                       input logic [31:0] e_load, input string tag);
      exp_t x;
      int   n;
      x.tag = tag;
      x.err = e_err;
      if (!w) begin
         x.rdata    = e_err ? 32'h0 : e_load;
         last_rd[s] = x.rdata;
      end else begin
         x.rdata = last_rd[s];
      end
      sb.push_back(x);
      check({tag, ":idle_busy"}, 32'(busy[s]), 32'h0);
      ce[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
      @(posedge clk); #1;
      // Scramble the request lines; the captured copy must be used.
      ce[s] = 1'b0; we[s] = ~w; addr[s] = ~a; wdata[s] = ~d;
      n = 1;
      while (ready[s] !== 1'b1 && n < 20) begin
         check({tag, ":wait_busy"}, 32'(busy[s]), 32'h1);
         @(posedge clk); #1;
         n++;
      end
      x = sb.pop_front();
      check({x.tag, ":ready"},   32'(ready[s]), 32'h1);
      check({x.tag, ":resp_busy"}, 32'(busy[s]), 32'h1);
      check({x.tag, ":latency"}, 32'(n), 32'(ws_of(s) + 1));
      if (ready[s] === 1'b1) begin
         check({x.tag, ":err"},   32'(err[s]), 32'(x.err));
         check({x.tag, ":rdata"}, rdata[s],    x.rdata);
      end
      @(posedge clk); #1;
      check({x.tag, ":pulse_end"}, 32'(ready[s]), 32'h0);
      check({x.tag, ":post_busy"}, 32'(busy[s]),  32'h0);
      check({x.tag, ":hold"},      rdata[s],      x.rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] bb_data [3];
      exp_t        x;
      bb_data = '{32'h0000_AAA0, 32'h0000_BBB4, 32'h0000_CCC8};
      for (int i = 0; i < 4; i++) begin
         ce[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
         last_rd[i] = 32'h0;
      end

      // Power-on reset: every instance quiet.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) check_idle_outputs(i, $sformatf("por%0d", i));
      rst = 1'b0;

      // Store then load on the main instance, then a store must not move rdata_o.
      xact(0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0,         "sw20");
      xact(0, 1'b0, 32'h20, 32'h0,         1'b0, 32'hCAFE_F00D, "lw20");
      xact(0, 1'b1, 32'h24, 32'h2424_2424, 1'b0, 32'h0,         "sw24_hold");
      xact(0, 1'b0, 32'h24, 32'h0,         1'b0, 32'h2424_2424, "lw24");

      // Reset in the middle of a store aborts it.
      xact(0, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 32'h0,         "sw10");
      xact(0, 1'b0, 32'h10, 32'h0,         1'b0, 32'h1111_1111, "lw10");
      ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      ce[0] = 1'b0;
      check("abort:wait_busy", 32'(busy[0]), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs(0, "rst_cyc1");
      @(posedge clk); #1;
      check_idle_outputs(0, "rst_cyc2");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("abort:no_ready%0d", i), 32'(ready[0]), 32'h0);
      end
      xact(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_1111, "lw10_after_rst");

      // Latency sweep on the zero-wait and three-wait instances.
      xact(1, 1'b1, 32'h40, 32'hA5A5_0001, 1'b0, 32'h0,         "ws0_sw40");
      xact(1, 1'b0, 32'h40, 32'h0,         1'b0, 32'hA5A5_0001, "ws0_lw40");
      xact(2, 1'b1, 32'h40, 32'h3C3C_0003, 1'b0, 32'h0,         "ws3_sw40");
      xact(2, 1'b0, 32'h40, 32'h0,         1'b0, 32'h3C3C_0003, "ws3_lw40");

      // Back-to-back stores with ce_i held high; wdata_i is corrupted after
      // each accept and ce_i stays high through RESP.
      ce[0] = 1'b1; we[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr[0]  = 32'(4 * k);
         wdata[0] = bb_data[k];
         x.tag    = $sformatf("b2b_sw%0d", k);
         x.err    = 1'b0;
         x.rdata  = last_rd[0];
         sb.push_back(x);
         @(posedge clk); #1;
         check({x.tag, ":accept_busy"}, 32'(busy[0]), 32'h1);
         wdata[0] = ~bb_data[k];
         addr[0]  = 32'h3;
         @(posedge clk); #1;
         x = sb.pop_front();
         check({x.tag, ":ready"}, 32'(ready[0]), 32'h1);
         check({x.tag, ":err"},   32'(err[0]),   32'(x.err));
         check({x.tag, ":rdata"}, rdata[0],      x.rdata);
         if (k == 2) ce[0] = 1'b0;
         @(posedge clk); #1;
         check({x.tag, ":gap_busy"},  32'(busy[0]),  32'h0);
         check({x.tag, ":gap_ready"}, 32'(ready[0]), 32'h0);
      end
      xact(0, 1'b0, 32'h0, 32'h0, 1'b0, bb_data[0], "b2b_lw0");
      xact(0, 1'b0, 32'h4, 32'h0, 1'b0, bb_data[1], "b2b_lw4");
      xact(0, 1'b0, 32'h8, 32'h0, 1'b0, bb_data[2], "b2b_lw8");

      // Error cases.
      xact(0, 1'b0, 32'h22,   32'h0,         1'b1, 32'h0,         "lw22_misaligned");
      xact(0, 1'b1, 32'hFFC,  32'h0BAD_CAFE, 1'b0, 32'h0,         "sw0ffc");
      xact(0, 1'b1, 32'h1000, 32'h1234_5678, 1'b1, 32'h0,         "sw1000_range");
      xact(0, 1'b0, 32'hFFC,  32'h0,         1'b0, 32'h0BAD_CAFE, "lw0ffc_kept");
      xact(0, 1'b0, 32'h0,    32'h0,         1'b0, bb_data[0],    "lw0_no_alias");
      xact(0, 1'b1, 32'h26,   32'h7777_7777, 1'b1, 32'h0,         "sw26_misaligned");
      xact(0, 1'b0, 32'h24,   32'h0,         1'b0, 32'h2424_2424, "lw24_kept");

      // Non-zero base address.
      xact(3, 1'b0, 32'h0FFC, 32'h0,         1'b1, 32'h0,         "base_lw0ffc");
      xact(3, 1'b1, 32'h1004, 32'h5A5A_5A5A, 1'b0, 32'h0,         "base_sw1004");
      xact(3, 1'b0, 32'h1004, 32'h0,         1'b0, 32'h5A5A_5A5A, "base_lw1004");
      xact(3, 1'b0, 32'h2000, 32'h0,         1'b1, 32'h0,         "base_lw2000");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
